// File: rtl/tmux_correlator_pkg.sv
// Shared definitions for the time-multiplexed 1-bit complex correlator.
//   sbits()      signed width needed for a sum of 'count' terms in {-2,0,+2}
//   T_*          term encoding (3-bit two's complement)
//   DEF_ATAPS    default antenna-A index per timeslice: slice s -> antenna s
//   DEF_BTAPS    default antenna-B index per timeslice: slice s -> antenna s+1
package tmux_correlator_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TRATE = 30;
  localparam int unsigned DEF_ABITS = $clog2(DEF_WIDTH);

  localparam logic signed [2:0] T_NEG2 = -3'sd2;
  localparam logic signed [2:0] T_ZERO = 3'sd0;
  localparam logic signed [2:0] T_POS2 = 3'sd2;

  function automatic int unsigned sbits(input int unsigned count);
    return $clog2(2 * count + 1) + 1;
  endfunction

  function automatic logic [DEF_TRATE*DEF_ABITS-1:0] make_taps(input int unsigned offset);
    logic [DEF_TRATE*DEF_ABITS-1:0] r;
    r = '0;
    for (int unsigned s = 0; s < DEF_TRATE; s++)
      r[s*DEF_ABITS +: DEF_ABITS] = DEF_ABITS'((s + offset) % DEF_WIDTH);
    return r;
  endfunction

  localparam logic [DEF_TRATE*DEF_ABITS-1:0] DEF_ATAPS = make_taps(0);
  localparam logic [DEF_TRATE*DEF_ABITS-1:0] DEF_BTAPS = make_taps(1);

endpackage

// File: rtl/tmux_correlator_cmul1b.sv
// Combinational 1-bit complex multiply A * conj(B), sign bits 1 => +1, 0 => -1.
//   ai, aq   antenna A in-phase / quadrature sign bits
//   bi, bq   antenna B in-phase / quadrature sign bits
//   tre      ai*bi + aq*bq  in {-2,0,+2}
//   tim      aq*bi - ai*bq  in {-2,0,+2}
module cmul1b
  import tmux_correlator_pkg::*;
(
  input  logic              ai,
  input  logic              aq,
  input  logic              bi,
  input  logic              bq,
  output logic signed [2:0] tre,
  output logic signed [2:0] tim
);

  // A product of two signs is +1 exactly when the bits agree (XNOR).
  logic p_ii, p_qq, p_qi, p_iq;

  always_comb begin
    p_ii = ai ~^ bi;
    p_qq = aq ~^ bq;
    p_qi = aq ~^ bi;
    p_iq = ai ~^ bq;

    case ({p_ii, p_qq})
      2'b11:   tre = T_POS2;
      2'b00:   tre = T_NEG2;
      default: tre = T_ZERO;
    endcase

    // Difference: +2 when the minuend is +1 and the subtrahend -1.
    case ({p_qi, p_iq})
      2'b10:   tim = T_POS2;
      2'b01:   tim = T_NEG2;
      default: tim = T_ZERO;
    endcase
  end

endmodule

// File: rtl/tmux_correlator.sv
// Time-multiplexed 1-bit complex correlator. Each timeslice selects an antenna
// pair through the ATAPS/BTAPS tables and accumulates A*conj(B) over
// COUNT = LOOP0*LOOP1 valid samples, emitting one signed (re,im) sum per slice.
// Pipeline: S1 tap capture, S2 term register, S3 accumulate/output.
//   vis_clk, vis_rst         clock, synchronous active-high reset
//   valid_i/first_i/last_i   sample strobe and bank framing
//   taddr_i                  timeslice index
//   idata_i/qdata_i          per-antenna I/Q sign bits
//   valid_o/last_o/taddr_o   completed-sum strobe, final-slice flag, slice
//   re_o/im_o                signed sums
//   sync_err_o               pulse when a slice is aborted by a framing violation
module tmux_correlator
  import tmux_correlator_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TRATE = DEF_TRATE,
  parameter int unsigned LOOP0 = 3,
  parameter int unsigned LOOP1 = 5,
  parameter logic [TRATE*$clog2(WIDTH)-1:0] ATAPS = DEF_ATAPS,
  parameter logic [TRATE*$clog2(WIDTH)-1:0] BTAPS = DEF_BTAPS,
  localparam int unsigned TBITS = $clog2(TRATE),
  localparam int unsigned SBITS = sbits(LOOP0 * LOOP1)
) (
  input  logic                    vis_clk,
  input  logic                    vis_rst,
  input  logic                    valid_i,
  input  logic                    first_i,
  input  logic                    last_i,
  input  logic [TBITS-1:0]        taddr_i,
  input  logic [WIDTH-1:0]        idata_i,
  input  logic [WIDTH-1:0]        qdata_i,
  output logic                    valid_o,
  output logic                    last_o,
  output logic [TBITS-1:0]        taddr_o,
  output logic signed [SBITS-1:0] re_o,
  output logic signed [SBITS-1:0] im_o,
  output logic                    sync_err_o
);

  localparam int unsigned COUNT = LOOP0 * LOOP1;
  localparam int unsigned ABITS = $clog2(WIDTH);
  localparam int unsigned CBITS = $clog2(COUNT + 1);
  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(COUNT - 1);

  // ---------------- tap selection ----------------
  logic [ABITS-1:0] a_idx, b_idx;

  always_comb begin
    a_idx = '0;
    b_idx = '0;
    for (int unsigned s = 0; s < TRATE; s++) begin
      if (taddr_i == TBITS'(s)) begin
        a_idx = ATAPS[s*ABITS +: ABITS];
        b_idx = BTAPS[s*ABITS +: ABITS];
      end
    end
  end

  // ---------------- S1 ----------------
  logic             s1_valid, s1_first, s1_last;
  logic [TBITS-1:0] s1_taddr;
  logic             s1_ai, s1_aq, s1_bi, s1_bq;

  always_ff @(posedge vis_clk) begin
    if (vis_rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_taddr <= '0;
      s1_ai    <= 1'b0;
      s1_aq    <= 1'b0;
      s1_bi    <= 1'b0;
      s1_bq    <= 1'b0;
    end else begin
      s1_valid <= valid_i;
      s1_first <= first_i;
      s1_last  <= last_i;
      s1_taddr <= taddr_i;
      s1_ai    <= idata_i[a_idx];
      s1_aq    <= qdata_i[a_idx];
      s1_bi    <= idata_i[b_idx];
      s1_bq    <= qdata_i[b_idx];
    end
  end

  logic signed [2:0] c_tre, c_tim;

  cmul1b u_cmul1b (
    .ai  (s1_ai),
    .aq  (s1_aq),
    .bi  (s1_bi),
    .bq  (s1_bq),
    .tre (c_tre),
    .tim (c_tim)
  );

  // ---------------- S2 ----------------
  logic              s2_valid, s2_first, s2_last;
  logic [TBITS-1:0]  s2_taddr;
  logic signed [2:0] s2_tre, s2_tim;

  always_ff @(posedge vis_clk) begin
    if (vis_rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_taddr <= '0;
      s2_tre   <= T_ZERO;
      s2_tim   <= T_ZERO;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_taddr <= s1_taddr;
      s2_tre   <= c_tre;
      s2_tim   <= c_tim;
    end
  end

  // ---------------- S3: accumulate and framing ----------------
  logic [CBITS-1:0]        cnt, eff_cnt;
  logic [TBITS-1:0]        slice_taddr;
  logic signed [SBITS-1:0] acc_re, acc_im, base_re, base_im, sum_re, sum_im;
  logic                    restart, last_bad, done;

  // A restart folds the abort into the same cycle: the aborting sample is
  // treated as sample 0 of a fresh slice, so one sync_err_o pulse covers
  // first_i and taddr changes together.
  always_comb begin
    restart  = (cnt != '0) && (s2_first || (s2_taddr != slice_taddr));
    eff_cnt  = restart ? '0 : cnt;
    base_re  = (eff_cnt == '0) ? '0 : acc_re;
    base_im  = (eff_cnt == '0) ? '0 : acc_im;
    sum_re   = base_re + SBITS'(s2_tre);
    sum_im   = base_im + SBITS'(s2_tim);
    last_bad = s2_last && (eff_cnt != CNT_LAST);
    done     = (eff_cnt == CNT_LAST);
  end

  always_ff @(posedge vis_clk) begin
    if (vis_rst) begin
      cnt         <= '0;
      slice_taddr <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      taddr_o     <= '0;
      re_o        <= '0;
      im_o        <= '0;
      sync_err_o  <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      sync_err_o <= 1'b0;
      if (s2_valid) begin
        slice_taddr <= s2_taddr;
        sync_err_o  <= restart | last_bad;
        if (last_bad) begin
          cnt    <= '0;
          acc_re <= '0;
          acc_im <= '0;
        end else if (done) begin
          valid_o <= 1'b1;
          last_o  <= s2_last;
          taddr_o <= s2_taddr;
          re_o    <= sum_re;
          im_o    <= sum_im;
          cnt     <= '0;
          acc_re  <= '0;
          acc_im  <= '0;
        end else begin
          cnt    <= eff_cnt + CBITS'(1);
          acc_re <= sum_re;
          acc_im <= sum_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmux_correlator.sv
module tb_tmux_correlator;

  localparam int COUNT = 15;
  localparam int TRATE = 30;
  localparam int NANT  = 32;

  logic              vis_clk = 1'b0;
  logic              vis_rst = 1'b1;
  logic              valid_i = 1'b0;
  logic              first_i = 1'b0;
  logic              last_i  = 1'b0;
  logic [4:0]        taddr_i = '0;
  logic [31:0]       idata_i = '0;
  logic [31:0]       qdata_i = '0;
  logic              valid_o, last_o, sync_err_o;
  logic [4:0]        taddr_o;
  logic signed [5:0] re_o, im_o;

  tmux_correlator dut (
    .vis_clk    (vis_clk),
    .vis_rst    (vis_rst),
    .valid_i    (valid_i),
    .first_i    (first_i),
    .last_i     (last_i),
    .taddr_i    (taddr_i),
    .idata_i    (idata_i),
    .qdata_i    (qdata_i),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .taddr_o    (taddr_o),
    .re_o       (re_o),
    .im_o       (im_o),
    .sync_err_o (sync_err_o)
  );

  always #5 vis_clk = ~vis_clk;

  int cyc = 0;
  always @(posedge vis_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int t;
    int re;
    int im;
    bit last;
  } ev_t;

  ev_t exp_ev[int];
  bit  exp_err[int];
  int  m_n = 0, m_re = 0, m_im = 0, m_t = 0;
  int  pushed = 0, seen = 0;

  function automatic int sgn(input logic b);
    return b ? 1 : -1;
  endfunction

  // Sample count and running complex sum of the open slice; events land 3
  // cycles after the input cycle.
  task automatic model(input bit v, f, l, input int t,
                       input logic [31:0] id, qd, input int c);
    int ar, aim, br, bim;
    bit err;
    ev_t e;
    if (!v) return;
    ar  = sgn(id[t]);
    aim = sgn(qd[t]);
    br  = sgn(id[(t + 1) % NANT]);
    bim = sgn(qd[(t + 1) % NANT]);
    err = 0;
    if (m_n != 0 && (f || t != m_t)) begin
      err = 1;
      m_n = 0;
    end
    if (m_n == 0) begin
      m_re = 0;
      m_im = 0;
      m_t  = t;
    end
    m_re += ar * br + aim * bim;
    m_im += aim * br - ar * bim;
    m_n++;
    if (l && m_n != COUNT) begin
      err = 1;
      m_n = 0;
    end else if (m_n == COUNT) begin
      e.t = t; e.re = m_re; e.im = m_im; e.last = l;
      exp_ev[c + 3] = e;
      pushed++;
      m_n = 0;
    end
    if (err) exp_err[c + 3] = 1'b1;
  endtask

  // ---------------- monitor ----------------
  bit chk_en = 0;
  int vo_count = 0, lo_count = 0, err_count = 0;

  always @(negedge vis_clk) begin
    if (chk_en) begin
      check("valid_o", {31'b0, valid_o}, exp_ev.exists(cyc));
      check("sync_err_o", {31'b0, sync_err_o}, exp_err.exists(cyc));
      if (valid_o === 1'b1) begin
        vo_count++;
        if (last_o === 1'b1) lo_count++;
      end
      if (sync_err_o === 1'b1) err_count++;
      if (exp_ev.exists(cyc) && valid_o === 1'b1) begin
        seen++;
        check("taddr_o", {27'b0, taddr_o}, exp_ev[cyc].t);
        check("re_o", re_o, exp_ev[cyc].re);
        check("im_o", im_o, exp_ev[cyc].im);
        check("last_o", {31'b0, last_o}, {31'b0, exp_ev[cyc].last});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, f, l, input int t, input logic [31:0] id, qd);
    @(posedge vis_clk);
    #1;
    vis_rst = 1'b0;
    valid_i = v;
    first_i = f;
    last_i  = l;
    taddr_i = 5'(t);
    idata_i = id;
    qdata_i = qd;
    model(v, f, l, t, id, qd, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, $urandom_range(1), $urandom_range(1), 0, $urandom, $urandom);
  endtask

  // Random background with antenna A (bit t) and B (bit t+1) forced.
  function automatic logic [31:0] pat(input int t, input bit a, input bit b);
    logic [31:0] r;
    r = $urandom;
    r[t] = a;
    r[(t + 1) % NANT] = b;
    return r;
  endfunction

  task automatic bank(input bit rnd, input bit ai, aq, bi, bq,
                      input int gap_pct, input int viol_pct);
    bit f, l;
    int t;
    for (int s = 0; s < TRATE; s++) begin
      for (int k = 0; k < COUNT; k++) begin
        f = (s == 0 && k == 0);
        l = (s == TRATE - 1 && k == COUNT - 1);
        t = s;
        if ($urandom_range(99) < viol_pct) f = 1;
        if ($urandom_range(99) < viol_pct) l = 1;
        if ($urandom_range(99) < viol_pct) t = $urandom_range(TRATE - 1);
        if (rnd) drive(1, f, l, t, $urandom, $urandom);
        else     drive(1, f, l, t, pat(t, ai, bi), pat(t, aq, bq));
        if ($urandom_range(99) < gap_pct) idle(1);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge vis_clk);
    #1;
    vis_rst = 1'b1;
    valid_i = 1'b0;
    m_n = 0;
    @(posedge vis_clk);
    @(negedge vis_clk);
    check("rst_valid_o", {31'b0, valid_o}, 0);
    check("rst_sync_err_o", {31'b0, sync_err_o}, 0);
    check("rst_re_o", re_o, 0);
    check("rst_im_o", im_o, 0);
    check("rst_taddr_o", {27'b0, taddr_o}, 0);
    check("rst_last_o", {31'b0, last_o}, 0);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge vis_clk);
    @(negedge vis_clk);
    check("por_valid_o", {31'b0, valid_o}, 0);
    check("por_sync_err_o", {31'b0, sync_err_o}, 0);
    check("por_re_o", re_o, 0);
    check("por_im_o", im_o, 0);
    check("por_taddr_o", {27'b0, taddr_o}, 0);
    check("por_last_o", {31'b0, last_o}, 0);
    idle(2);
    chk_en = 1;

    // 1: all bits one
    vo_count = 0; lo_count = 0; err_count = 0;
    for (int s = 0; s < TRATE; s++)
      for (int k = 0; k < COUNT; k++)
        drive(1, s == 0 && k == 0, s == TRATE - 1 && k == COUNT - 1, s, '1, '1);
    idle(4);
    check("t1_valid_count", vo_count, 30);
    check("t1_last_count", lo_count, 1);
    check("t1_err_count", err_count, 0);

    // 2: B inverted; 3: quadrature cases
    bank(0, 1, 1, 0, 0, 0, 0);
    bank(0, 1, 1, 1, 0, 0, 0);
    bank(0, 1, 1, 0, 1, 0, 0);
    idle(4);

    // 4: gap after every 2nd sample of slice 0
    err_count = 0; vo_count = 0;
    for (int k = 0; k < COUNT; k++) begin
      drive(1, k == 0, 0, 0, pat(0, 1, 1), pat(0, 1, 1));
      if (k % 2 == 1) idle(1);
    end
    idle(4);
    check("t4_err_count", err_count, 0);
    check("t4_valid_count", vo_count, 1);

    // 5: first_i reasserted after 7 samples
    err_count = 0; vo_count = 0;
    for (int k = 0; k < 7; k++) drive(1, k == 0, 0, 0, '1, '1);
    for (int k = 0; k < COUNT; k++) drive(1, k == 0, 0, 0, '1, '1);
    idle(4);
    check("t5_err_count", err_count, 1);
    check("t5_valid_count", vo_count, 1);

    // 6: reset after 10 samples of slice 3
    vo_count = 0;
    for (int k = 0; k < 10; k++) drive(1, 0, 0, 3, '1, '1);
    idle(3);
    do_reset();
    for (int k = 0; k < COUNT; k++) drive(1, 0, 0, 3, pat(3, 1, 0), pat(3, 1, 0));
    idle(4);
    check("t6_valid_count", vo_count, 1);

    // Randomized banks with gaps and occasional framing violations
    for (int b = 0; b < 3; b++) bank(1, 0, 0, 0, 0, 20, 2);
    idle(6);

    check("events_seen", seen, pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
